// File: rtl/bm_if_pkg.sv
// -----------------------------------------------------------------------------
// bm_if_pkg
// Shared definitions for the if-common collector slice: operand width, word
// width helper, serializer state encoding and the packed sample word layout.
// Optional feature macro: BM_IF_COLLECT_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package bm_if_pkg;

   localparam int unsigned BITS = 2;

   function automatic int unsigned word_w(input int unsigned bits);
      return 2 * bits + 1;
   endfunction

   localparam int unsigned W = word_w(BITS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
`ifdef BM_IF_COLLECT_PARITY_EN
      , ST_PARITY = 2'd2
`endif
   } ser_state_e;

   // Bit 0 is out0[0]; the MSB is out1.
   typedef struct packed {
      logic            out1;
      logic [BITS-1:0] out2;
      logic [BITS-1:0] out0;
   } word_t;

endpackage

// File: rtl/bm_if_fifo.sv
// -----------------------------------------------------------------------------
// bm_if_fifo
// Synchronous FIFO with registered full/empty flags.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din (ignored when full)
//   pop    in   advance the read pointer (ignored when empty)
//   din    in   WIDTH write data
//   dout   out  WIDTH head-of-queue data (valid when empty=0)
//   full   out  registered, count == DEPTH
//   empty  out  registered, count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bm_if_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW:0]      w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push & ~r_full;
   assign w_do_pop  = pop & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/bm_if_collect.sv
// -----------------------------------------------------------------------------
// bm_if_collect
// Samples {out1, out2, out0} on qualified cycles, buffers the words in a FIFO
// and serializes each word LSB-first on a framed single-bit output. Saturating
// counters track accepted hits (out1=1) and samples dropped while full.
// Optional feature macro: BM_IF_COLLECT_PARITY_EN appends an even-parity bit.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   sample_en   in   capture the current operands
//   out0_in     in   BITS upstream out0
//   out2_in     in   BITS upstream out2
//   out1_in     in   upstream out1
//   ser_out     out  registered serial data, LSB first
//   ser_frame   out  registered, high while ser_out carries a valid bit
//   fifo_full   out  FIFO holds DEPTH words
//   fifo_empty  out  FIFO holds no words
//   hit_cnt     out  CNT_W accepted samples with out1_in=1 (saturating)
//   drop_cnt    out  CNT_W samples rejected while full (saturating)
// -----------------------------------------------------------------------------
module bm_if_collect
   import bm_if_pkg::*;
#(
   parameter int unsigned BITS  = bm_if_pkg::BITS,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [BITS-1:0]  out0_in,
   input  logic [BITS-1:0]  out2_in,
   input  logic             out1_in,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned    WORD_W   = word_w(BITS);
   localparam int unsigned    BCW      = $clog2(WORD_W);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

   logic [WORD_W-1:0] w_din;
   logic [WORD_W-1:0] w_dout;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;

   ser_state_e        r_state;
   ser_state_e        w_state_nxt;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] w_shift_nxt;
   logic [BCW-1:0]    r_bitcnt;
   logic [BCW-1:0]    w_bitcnt_nxt;
   logic              r_ser_out;
   logic              w_ser_out_nxt;
   logic              r_ser_frame;
   logic              w_ser_frame_nxt;
`ifdef BM_IF_COLLECT_PARITY_EN
   logic              r_par;
   logic              w_par_nxt;
`endif
   logic [CNT_W-1:0]  r_hit;
   logic [CNT_W-1:0]  r_drop;

   assign w_din  = {out1_in, out2_in, out0_in};
   assign w_push = sample_en & ~w_full;
   // A full FIFO rejects the sample even if the serializer pops on this edge.
   assign w_drop = sample_en & w_full;

   bm_if_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit  <= '0;
         r_drop <= '0;
      end else begin
         if (w_push && out1_in && (r_hit != '1)) r_hit  <= r_hit + CNT_W'(1);
         if (w_drop && (r_drop != '1))           r_drop <= r_drop + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_ser_out   <= 1'b0;
         r_ser_frame <= 1'b0;
`ifdef BM_IF_COLLECT_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_ser_out   <= w_ser_out_nxt;
         r_ser_frame <= w_ser_frame_nxt;
`ifdef BM_IF_COLLECT_PARITY_EN
         r_par       <= w_par_nxt;
`endif
      end
   end

   // Serial outputs are registered, so this block computes the value they take
   // after the edge: the popped word's bit 0 is presented on the pop edge and
   // r_shift[0] always mirrors the bit currently on ser_out.
   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bitcnt_nxt    = r_bitcnt;
      w_ser_out_nxt   = 1'b0;
      w_ser_frame_nxt = 1'b0;
      w_pop           = 1'b0;
`ifdef BM_IF_COLLECT_PARITY_EN
      w_par_nxt       = r_par;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop           = 1'b1;
               w_shift_nxt     = w_dout;
               w_bitcnt_nxt    = '0;
               w_ser_out_nxt   = w_dout[0];
               w_ser_frame_nxt = 1'b1;
               w_state_nxt     = ST_SHIFT;
`ifdef BM_IF_COLLECT_PARITY_EN
               w_par_nxt       = ^w_dout;
`endif
            end
         end
         ST_SHIFT: begin
            if (r_bitcnt == LAST_BIT) begin
`ifdef BM_IF_COLLECT_PARITY_EN
               w_ser_out_nxt   = r_par;
               w_ser_frame_nxt = 1'b1;
               w_state_nxt     = ST_PARITY;
`else
               w_state_nxt     = ST_IDLE;
`endif
            end else begin
               w_shift_nxt     = r_shift >> 1;
               w_ser_out_nxt   = r_shift[1];
               w_ser_frame_nxt = 1'b1;
               w_bitcnt_nxt    = r_bitcnt + BCW'(1);
            end
         end
`ifdef BM_IF_COLLECT_PARITY_EN
         ST_PARITY: begin
            w_state_nxt = ST_IDLE;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ser_out    = r_ser_out;
   assign ser_frame  = r_ser_frame;
   assign fifo_full  = w_full;
   assign fifo_empty = w_empty;
   assign hit_cnt    = r_hit;
   assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_bm_if_collect.sv
// -----------------------------------------------------------------------------
// tb_bm_if_collect
// Randomized and directed stimulus for bm_if_collect. A cycle-level reference
// model (queue of buffered words plus a busy countdown for the serializer)
// pushes expected status per cycle and expected frames per accepted sample; a
// separate monitor pops and compares on the falling edge.
// Optional feature macro: BM_IF_COLLECT_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_bm_if_collect;
   import bm_if_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CNT_W   = 8;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef BM_IF_COLLECT_PARITY_EN
   localparam int          FRAME   = W + 1;
`else
   localparam int          FRAME   = W;
`endif

   logic             clock     = 1'b0;
   logic             reset     = 1'b0;
   logic             sample_en = 1'b0;
   logic [BITS-1:0]  out0_in   = '0;
   logic [BITS-1:0]  out2_in   = '0;
   logic             out1_in   = 1'b0;
   logic             ser_out;
   logic             ser_frame;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   bm_if_collect #(
      .BITS  (BITS),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sample_en  (sample_en),
      .out0_in    (out0_in),
      .out2_in    (out2_in),
      .out1_in    (out1_in),
      .ser_out    (ser_out),
      .ser_frame  (ser_frame),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .hit_cnt    (hit_cnt),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   typedef struct {
      bit full;
      bit empty;
      bit frame;
      bit sout;
      int hit;
      int drop;
   } st_t;

   st_t            st_q[$];
   logic [W-1:0]   exp_frames[$];
   logic [W-1:0]   m_fifo[$];
   logic [W-1:0]   m_cur = '0;
   int             m_busy = 0;
   int             m_hit  = 0;
   int             m_drop = 0;

   function automatic logic [W-1:0] pack_word(input int a, input int b, input int c);
      int v;
      v = c * (1 << (2 * BITS)) + b * (1 << BITS) + a;
      return W'(v);
   endfunction

   function automatic bit even_par(input logic [W-1:0] w);
      return ($countones(w) % 2) == 1;
   endfunction

   // Reference model: evaluated on each rising edge with the pre-edge inputs.
   initial begin
      st_t          s;
      int           sz;
      int           idx;
      bit           was_full;
      logic [W-1:0] wd;
      forever begin
         @(posedge clock);
         if (reset) begin
            m_fifo.delete();
            exp_frames.delete();
            m_busy = 0;
            m_hit  = 0;
            m_drop = 0;
         end else begin
            sz       = m_fifo.size();
            was_full = (sz == DEPTH);
            if (m_busy == 0 && sz > 0) begin
               m_cur  = m_fifo.pop_front();
               m_busy = FRAME;
            end else if (m_busy > 0) begin
               m_busy--;
            end
            if (sample_en) begin
               if (was_full) begin
                  if (m_drop < CNT_MAX) m_drop++;
               end else begin
                  wd = pack_word(int'(out0_in), int'(out2_in), int'(out1_in));
                  m_fifo.push_back(wd);
                  exp_frames.push_back(wd);
                  if (out1_in && m_hit < CNT_MAX) m_hit++;
               end
            end
            s.full  = (m_fifo.size() == DEPTH);
            s.empty = (m_fifo.size() == 0);
            s.frame = (m_busy > 0);
            idx     = FRAME - m_busy;
            if (m_busy == 0)  s.sout = 1'b0;
            else if (idx < W) s.sout = m_cur[idx];
            else              s.sout = even_par(m_cur);
            s.hit   = m_hit;
            s.drop  = m_drop;
            st_q.push_back(s);
         end
      end
   end

   // Monitor: per-cycle status plus frame reassembly against the scoreboard.
   logic [W:0] got_bits = '0;
   int         got_len  = 0;
   initial begin
      st_t          s;
      logic [W-1:0] e;
      forever begin
         @(negedge clock);
         if (reset) begin
            got_len = 0;
            st_q.delete();
         end else begin
            if (st_q.size() > 0) begin
               s = st_q.pop_front();
               chk("fifo_full",  fifo_full,  s.full);
               chk("fifo_empty", fifo_empty, s.empty);
               chk("ser_frame",  ser_frame,  s.frame);
               chk("ser_out",    ser_out,    s.sout);
               chk("hit_cnt",    hit_cnt,    s.hit);
               chk("drop_cnt",   drop_cnt,   s.drop);
            end
            if (ser_frame) begin
               if (got_len <= W) got_bits[got_len] = ser_out;
               got_len++;
            end else begin
               chk("idle_ser_out", ser_out, 0);
               if (got_len > 0) begin
                  if (exp_frames.size() == 0) begin
                     chk("unexpected_frame_len", got_len, 0);
                  end else begin
                     e = exp_frames.pop_front();
                     chk("frame_len", got_len, FRAME);
                     chk("frame_word", got_bits[W-1:0], e);
`ifdef BM_IF_COLLECT_PARITY_EN
                     chk("frame_parity", got_bits[W], even_par(e));
`endif
                  end
                  got_len = 0;
               end
            end
         end
      end
   end

   task automatic drive(input bit en, input int a, input int b, input int c);
      @(negedge clock);
      sample_en = en;
      out0_in   = BITS'(a);
      out2_in   = BITS'(b);
      out1_in   = c[0];
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   localparam int DRAIN = (DEPTH + 2) * (FRAME + 1) + 4;

   initial begin
      #2 reset = 1'b1;
      #1;
      chk("rst_ser_out",    ser_out,    0);
      chk("rst_ser_frame",  ser_frame,  0);
      chk("rst_fifo_empty", fifo_empty, 1);
      chk("rst_fifo_full",  fifo_full,  0);
      chk("rst_hit_cnt",    hit_cnt,    0);
      chk("rst_drop_cnt",   drop_cnt,   0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Quiet period, then the single 5'b11001 sample.
      idle(20);
      drive(1, 1, 2, 1);
      idle(DRAIN);

      // Sustained capture of one constant word: fills and then drops.
      repeat (12) drive(1, 3, 1, 0);
      idle(DRAIN);

      // Random traffic, including pushes against a full FIFO while popping.
      repeat (400) drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      idle(DRAIN);

      // Paced hits, never full, to drive hit_cnt into saturation.
      repeat (300) begin
         drive(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
         idle(FRAME + 1);
      end
      idle(DRAIN);
      chk("hit_saturated", hit_cnt, CNT_MAX);

      // Reset in the middle of a frame.
      drive(1, 2, 1, 0);
      drive(1, 1, 1, 1);
      sample_en = 1'b0;
      for (int i = 0; i < 20 && ser_frame !== 1'b1; i++) @(negedge clock);
      chk("frame_started", ser_frame, 1);
      repeat (2) @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midrst_ser_frame",  ser_frame,  0);
      chk("midrst_fifo_empty", fifo_empty, 1);
      chk("midrst_hit_cnt",    hit_cnt,    0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      idle(3);
      drive(1, 1, 2, 1);
      idle(DRAIN);

      chk("frames_outstanding", exp_frames.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
